// File: rtl/ks_pkg.sv
// Shared types and sizing helpers for the serial Kogge-Stone adder controller.
package ks_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nslice);
    int w;
    w = $clog2(nslice);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ks_add4.sv
// Combinational 4-bit Kogge-Stone adder: two prefix levels, carry-in folded in at the end.
module ks_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g0, p0, g1, p1, g2, p2;
  logic [4:0] c;

  assign g0 = a & b;
  assign p0 = a ^ b;

  // Level 1 combines span 1, level 2 span 2, giving full 4-bit group terms.
  assign g1[0] = g0[0];
  assign p1[0] = p0[0];
  assign g1[3:1] = g0[3:1] | (p0[3:1] & g0[2:0]);
  assign p1[3:1] = p0[3:1] & p0[2:0];

  assign g2[1:0] = g1[1:0];
  assign p2[1:0] = p1[1:0];
  assign g2[3:2] = g1[3:2] | (p1[3:2] & g1[1:0]);
  assign p2[3:2] = p1[3:2] & p1[1:0];

  assign c[0]   = cin;
  assign c[4:1] = g2 | (p2 & {4{cin}});

  assign s    = p0 ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/ks_serial_add_ctrl.sv
// Wide adder that time-shares one 4-bit Kogge-Stone slice, one nibble per cycle LSB first.
module ks_serial_add_ctrl
  import ks_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IW     = idx_width(NSLICE);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_width_chk
    $error("ks_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t               state;
  logic [IW-1:0]        idx;
  logic [WIDTH-1:0]     a_reg, b_reg;
  logic                 carry;
  logic [SLICE_W-1:0]   sl_a, sl_b, sl_s;
  logic                 sl_co;
  logic                 last, accept;

  assign sl_a   = a_reg[SLICE_W*idx +: SLICE_W];
  assign sl_b   = b_reg[SLICE_W*idx +: SLICE_W];
  assign last   = (idx == IW'(NSLICE - 1));
  assign busy   = (state == ST_RUN);
  assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign accept = in_valid & in_ready;

  ks_add4 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (abort) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum[SLICE_W*idx +: SLICE_W] <= sl_s;
          carry <= sl_co;
          idx   <= idx + 1'b1;
          if (last) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            cout      <= sl_co;
            // sl_s[3] is the new sum MSB on the final slice.
            ovf       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (sl_s[SLICE_W-1] != a_reg[WIDTH-1]);
          end
        end
        ST_DONE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry     <= cin;
            idx       <= '0;
            out_valid <= 1'b0;
            state     <= ST_RUN;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ks_serial_add_ctrl.sv
// Bench for ks_serial_add_ctrl: directed vectors, random sweep and a cycle-level reference model.
module tb_ks_serial_add_ctrl;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_pass = 0;
  int n_total = 0;

  ks_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: an accepted operation produces a+b+cin exactly NSLICE edges later.
  int           m_state = 0;   // 0 idle, 1 computing, 2 result presented
  int           m_cnt = 0;
  bit           m_known = 1'b1;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_sum;
  logic         p_cout, p_ovf;
  logic [W:0]   t;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_cnt = 0; m_known = 1'b1;
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (abort) begin
      if (m_state == 1) m_known = 1'b0;
      m_state = 0;
    end else begin
      if (in_valid && (m_state == 0 || (m_state == 2 && out_ready))) begin
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        p_sum  = t[W-1:0];
        p_cout = t[W];
        p_ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        m_state = 1; m_cnt = NSLICE; m_known = 1'b0;
      end else if (m_state == 2 && out_ready) begin
        m_state = 0;
      end else if (m_state == 1) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_state = 2; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf; m_known = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mdl_out_valid", {31'b0, out_valid}, {31'b0, m_state == 2});
      chk("mdl_in_ready", {31'b0, in_ready},
          {31'b0, (m_state == 0) || (m_state == 2 && out_ready)});
      chk("mdl_busy", {31'b0, busy}, {31'b0, m_state == 1});
      if (m_state != 1 && m_known) begin
        chk("mdl_sum", {16'b0, sum}, {16'b0, m_sum});
        chk("mdl_cout", {31'b0, cout}, {31'b0, m_cout});
        chk("mdl_ovf", {31'b0, ovf}, {31'b0, m_ovf});
      end
    end
  end

  // Accept one operation, wait for the result, compare with literals, then let it hand off.
  task automatic op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                    input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, n, NSLICE);
    chk({nm, "_sum"}, {16'b0, sum}, {16'b0, es});
    chk({nm, "_cout"}, {31'b0, cout}, {31'b0, ec});
    chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] sa, sb, s1;
    logic         sc, c1, o1;
    logic [W:0]   tt;
    int           n, g;

    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_sum", {16'b0, sum}, 32'd0);
    chk("rst_cout_ovf", {30'b0, cout, ovf}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    op("v1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op("v2", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    op("v3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op("v4", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure
    a = 16'h00F0; b = 16'h0F01; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_sum", {16'b0, sum}, 32'h0FF2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_sum", {16'b0, sum}, 32'h0FF2);
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_idle", {30'b0, in_ready, busy}, 32'd2);

    // Back-to-back
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 16'hF000; b = 16'h1000; cin = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("b2b_first_sum", {16'b0, sum}, 32'h3333);
    g = 0;
    @(posedge clk); #1; g++;
    in_valid = 1'b0;
    while (!out_valid && g < 50) begin @(posedge clk); #1; g++; end
    chk("b2b_gap", g, NSLICE + 1);
    chk("b2b_second_sum", {16'b0, sum}, 32'h0001);
    chk("b2b_second_cout", {31'b0, cout}, 32'd1);
    @(posedge clk); #1;

    // Abort at the 2nd RUN cycle
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    op("post_abort", 16'h00FF, 16'h0F0F, 1'b0, 16'h100E, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN
    a = 16'hBEEF; b = 16'h1234; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_busy_valid", {30'b0, busy, out_valid}, 32'd0);
    chk("arst_sum", {16'b0, sum}, 32'd0);
    chk("arst_cout_ovf", {30'b0, cout, ovf}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op("post_rst", 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      sa = W'($urandom); sb = W'($urandom); sc = 1'($urandom);
      tt = {1'b0, sa} + {1'b0, sb} + {{W{1'b0}}, sc};
      s1 = tt[W-1:0]; c1 = tt[W];
      o1 = (sa[W-1] == sb[W-1]) && (s1[W-1] != sa[W-1]);
      op("rand", sa, sb, sc, s1, c1, o1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
